nonce_scan_ctrl: RTL and testbench
==================================

# nonce_scan_ctrl

Sequences the double-SHA-256 header hasher across a nonce range for one mining job. It accepts a job (80-byte header template, inclusive nonce range, 256-bit target) and inserts each nonce into the header. It launches one hash at a time, compares each digest against the target, and reports hits and job completion. It sits between the work-distribution logic and the single hasher instance, which is its only datapath.

## Interface
Parameters:
- STOP_ON_HIT, 1, 1: end the job at the first hit; 0: report every hit and scan the full range.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- work_valid  in  1  job offered
- work_ready  out  1  high in IDLE; job accepted on work_valid & work_ready
- work_header  in  640  big-endian header; bits [31:0] (nonce field) ignored
- work_nonce_start  in  32  first nonce
- work_nonce_end  in  32  last nonce, inclusive
- work_target  in  256  unsigned target
- abort  in  1  request early job end
- hash_start  out  1  one-cycle launch pulse to hasher
- hash_header  out  640  header presented to hasher
- hash_ready  in  1  hasher can accept start
- hash_digest  in  256  hasher digest, big-endian bytes
- hash_valid  in  1  digest valid pulse
- found_valid  out  1  one-cycle hit pulse
- found_nonce  out  32  nonce of the hit
- found_hash  out  256  digest of the hit, as received
- done  out  1  one-cycle job-complete pulse
- done_status  out  2  0 EXHAUSTED, 1 HIT, 2 ABORTED; valid with done, held until next done
- busy  out  1  high in every state except IDLE
- hash_count  out  33  completed hashes in current job; cleared on accept

## Operation
- States: IDLE, LAUNCH, WAIT, EVAL, FINISH.
- IDLE: on accept, latch header, start, end and target; set nonce = start; clear hash_count and abort_pending; go to LAUNCH.
- LAUNCH: if hash_ready, pulse hash_start and go to WAIT; otherwise stay in LAUNCH.
- WAIT: on hash_valid, register the digest, increment hash_count, go to EVAL.
- EVAL:
  - hit = bswap256(digest) <= target (unsigned, little-endian integer).
  - On hit: set found_valid, found_nonce and found_hash.
  - Next state, first match wins: hit & STOP_ON_HIT → FINISH(HIT); nonce == end → FINISH(EXHAUSTED); abort_pending → FINISH(ABORTED); else nonce += 1 (mod 2^32) → LAUNCH.
- FINISH: done = 1, go to IDLE.
- hash_header = {header[639:32], bswap32(nonce)}: the nonce is stored little-endian in the header. hash_header is stable from LAUNCH through WAIT, because the hasher samples it throughout the hash.
- abort:
  - Latched into abort_pending in any busy cycle.
  - Honoured only in EVAL; an in-flight hash is never cancelled.
  - Ignored in IDLE.
  - A hit in the same EVAL still reports, with status HIT if STOP_ON_HIT.
- Range rules:
  - The range wraps when end < start, e.g. FFFFFFFE..00000001.
  - start == end performs one hash.
  - end == start−1 performs 2^32 hashes; hash_count is 33 bits to cover this.
- hash_start is never asserted in two consecutive cycles. It is low for at least one cycle after hash_valid (EVAL), which lets the hasher leave its done state before the next launch.

## Timing
- Reset values: work_ready 0 while rst_n low, 1 after release; all other outputs 0, including hash_header; state IDLE; abort_pending 0.
- Reset mid-job drops the job silently: no done pulse and no found pulse. The hasher shares rst_n.
- Job accept in cycle T → LAUNCH at T+1; hash_start at T+1 if hash_ready.
- hash_valid in cycle W → EVAL at W+1. At W+2: found_valid (if hit), and either done (FINISH) or next hash_start (LAUNCH, hash_ready high).
- found_valid, done and hash_count are registered outputs.
- Back-to-back jobs: work_ready returns one cycle after done.

## Structure
- Shared package miner_pkg holds:
  - the state enum;
  - the done_status enum;
  - the functions bswap32 and bswap256.
- One sub-module, hash_target_cmp, is natural: byte-swap plus 256-bit ≤ compare, purely combinational, fed from the registered digest.
- The hasher (sha256_double) is external and connected through the hash_* ports.

## Test plan
1. Genesis block header, range 7C2BAC1D..7C2BAC1D, target 00000000FFFF0000…0 → found_nonce 7C2BAC1D, bswap256(found_hash) = 000000000019d668…8ce26f, done_status HIT, hash_count 1.
2. Same header and target, range 7C2BAC1A..7C2BAC1F → hashes at nonces 1A, 1B, 1C, 1D, hit at 1D, no hash_start for 1E, hash_count 4.
3. Target 0, range FFFFFFFE..00000001 → hash_header[31:0] sequence FEFFFFFF, FFFFFFFF, 00000000, 01000000; no found_valid; EXHAUSTED; hash_count 4.
4. Range 0..99, abort pulsed during the first WAIT → that hash completes, no second hash_start, ABORTED, hash_count 1.
5. Target all-ones, STOP_ON_HIT=0, range 10..12 → three found_valid pulses with nonces 10, 11, 12, then EXHAUSTED.
6. Hasher model holding hash_ready low 5 cycles → hash_start deferred and never in consecutive cycles. rst_n low during WAIT → all outputs at reset values; work_ready 1 after release.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and byte-order helpers for the nonce scanner.
// Holds the FSM state enum, the done_status enum, bswap32 and bswap256.
package miner_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EVAL,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ST_EXHAUSTED = 2'd0,
    ST_HIT       = 2'd1,
    ST_ABORTED   = 2'd2
  } status_t;

  function automatic logic [31:0] bswap32(
    input logic [31:0] x
  );
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(
    input logic [255:0] x
  );
    logic [255:0] y;
    for (int i = 0; i < 32; i++)
      y[8*i +: 8] = x[255-8*i -: 8];
    return y;
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Byte-swapped digest vs target compare (hit when digest <= target).
// Ports: digest (big-endian bytes), target (unsigned), hit.
module hash_target_cmp
  import miner_pkg::*;
(
  input  logic [255:0] digest,
  input  logic [255:0] target,
  output logic         hit
);

  assign hit = bswap256(digest) <= target;

endmodule

// File: rtl/nonce_scan_ctrl.sv
// Scans a nonce range through one double-SHA-256 hasher, reports hits.
// Ports: work_* job in, hash_* hasher link, found_*/done* results, busy.
module nonce_scan_ctrl
  import miner_pkg::*;
#(
  parameter bit STOP_ON_HIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [639:0] work_header,
  input  logic [31:0]  work_nonce_start,
  input  logic [31:0]  work_nonce_end,
  input  logic [255:0] work_target,
  input  logic         abort,
  output logic         hash_start,
  output logic [639:0] hash_header,
  input  logic         hash_ready,
  input  logic [255:0] hash_digest,
  input  logic         hash_valid,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         done,
  output logic [1:0]   done_status,
  output logic         busy,
  output logic [32:0]  hash_count
);

  state_t         state;
  logic [607:0]   hdr_q;
  logic [31:0]    nonce_q;
  logic [31:0]    end_q;
  logic [255:0]   target_q;
  logic [255:0]   digest_q;
  logic           abort_pending;
  logic           hit;
  logic           unused_nonce_field;

  // The template's nonce field is replaced by the live nonce.
  assign unused_nonce_field = ^work_header[31:0];

  hash_target_cmp u_cmp (
    .digest (digest_q),
    .target (target_q),
    .hit    (hit)
  );

  assign busy        = state != S_IDLE;
  assign hash_start  = (state == S_LAUNCH) && hash_ready;
  assign hash_header = {hdr_q, bswap32(nonce_q)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      work_ready    <= 1'b0;
      hdr_q         <= '0;
      nonce_q       <= '0;
      end_q         <= '0;
      target_q      <= '0;
      digest_q      <= '0;
      abort_pending <= 1'b0;
      found_valid   <= 1'b0;
      found_nonce   <= '0;
      found_hash    <= '0;
      done          <= 1'b0;
      done_status   <= ST_EXHAUSTED;
      hash_count    <= '0;
    end else begin
      found_valid <= 1'b0;
      done        <= 1'b0;
      if (state != S_IDLE && abort)
        abort_pending <= 1'b1;
      unique case (state)
        S_IDLE: begin
          work_ready <= 1'b1;
          if (work_valid && work_ready) begin
            work_ready    <= 1'b0;
            hdr_q         <= work_header[639:32];
            nonce_q       <= work_nonce_start;
            end_q         <= work_nonce_end;
            target_q      <= work_target;
            hash_count    <= '0;
            abort_pending <= 1'b0;
            state         <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (hash_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (hash_valid) begin
            digest_q   <= hash_digest;
            hash_count <= hash_count + 33'd1;
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (hit) begin
            found_valid <= 1'b1;
            found_nonce <= nonce_q;
            found_hash  <= digest_q;
          end
          if (hit && STOP_ON_HIT) begin
            done        <= 1'b1;
            done_status <= ST_HIT;
            state       <= S_FINISH;
          end else if (nonce_q == end_q) begin
            done        <= 1'b1;
            done_status <= ST_EXHAUSTED;
            state       <= S_FINISH;
          end else if (abort_pending) begin
            done        <= 1'b1;
            done_status <= ST_ABORTED;
            state       <= S_FINISH;
          end else begin
            nonce_q <= nonce_q + 32'd1;
            state   <= S_LAUNCH;
          end
        end
        S_FINISH: begin
          work_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_scan_ctrl.sv
// Randomized bench for nonce_scan_ctrl with a stand-in hasher model.
// Two instances (STOP_ON_HIT 0/1) share stimulus; sel picks the active one.
module tb_nonce_scan_ctrl;

  localparam logic [255:0] GEN_LE =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] GEN_TGT = 256'hFFFF << 208;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic         work_valid = 1'b0;
  logic [639:0] work_header = '0;
  logic [31:0]  work_nonce_start = '0;
  logic [31:0]  work_nonce_end = '0;
  logic [255:0] work_target = '0;
  logic         abort = 1'b0;
  logic         hash_valid = 1'b0;
  logic [255:0] hash_digest = '0;
  logic         stall = 1'b0;
  logic         hm_busy = 1'b0;
  logic         hash_ready;
  logic         sel = 1'b1;

  assign hash_ready = !hm_busy && !stall;

  logic         wv [2];
  logic         hv [2];
  logic         wr [2];
  logic         hs [2];
  logic [639:0] hh [2];
  logic         fv [2];
  logic [31:0]  fn [2];
  logic [255:0] fh [2];
  logic         dn [2];
  logic [1:0]   ds [2];
  logic         by [2];
  logic [32:0]  hc [2];

  assign wv[0] = work_valid && (sel == 1'b0);
  assign wv[1] = work_valid && (sel == 1'b1);
  assign hv[0] = hash_valid && (sel == 1'b0);
  assign hv[1] = hash_valid && (sel == 1'b1);

  logic         work_ready, hash_start, found_valid, done, busy;
  logic [639:0] hash_header;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [1:0]   done_status;
  logic [32:0]  hash_count;

  assign work_ready  = wr[sel];
  assign hash_start  = hs[sel];
  assign hash_header = hh[sel];
  assign found_valid = fv[sel];
  assign found_nonce = fn[sel];
  assign found_hash  = fh[sel];
  assign done        = dn[sel];
  assign done_status = ds[sel];
  assign busy        = by[sel];
  assign hash_count  = hc[sel];

  nonce_scan_ctrl #(.STOP_ON_HIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .work_valid(wv[0]), .work_ready(wr[0]),
    .work_header(work_header),
    .work_nonce_start(work_nonce_start),
    .work_nonce_end(work_nonce_end),
    .work_target(work_target), .abort(abort),
    .hash_start(hs[0]), .hash_header(hh[0]),
    .hash_ready(hash_ready), .hash_digest(hash_digest),
    .hash_valid(hv[0]),
    .found_valid(fv[0]), .found_nonce(fn[0]), .found_hash(fh[0]),
    .done(dn[0]), .done_status(ds[0]), .busy(by[0]),
    .hash_count(hc[0])
  );

  nonce_scan_ctrl #(.STOP_ON_HIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .work_valid(wv[1]), .work_ready(wr[1]),
    .work_header(work_header),
    .work_nonce_start(work_nonce_start),
    .work_nonce_end(work_nonce_end),
    .work_target(work_target), .abort(abort),
    .hash_start(hs[1]), .hash_header(hh[1]),
    .hash_ready(hash_ready), .hash_digest(hash_digest),
    .hash_valid(hv[1]),
    .found_valid(fv[1]), .found_nonce(fn[1]), .found_hash(fh[1]),
    .done(dn[1]), .done_status(ds[1]), .busy(by[1]),
    .hash_count(hc[1])
  );

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 4; i++) y[8*i +: 8] = x[8*(3-i) +: 8];
    return y;
  endfunction

  function automatic logic [255:0] rev256(input logic [255:0] x);
    logic [255:0] y;
    for (int i = 0; i < 32; i++) y[8*i +: 8] = x[8*(31-i) +: 8];
    return y;
  endfunction

  // Stand-in for double SHA-256: genesis digest for the genesis nonce,
  // a deterministic scramble of header words otherwise.
  function automatic logic [255:0] fake_digest(input logic [639:0] h);
    logic [255:0] d;
    logic [31:0]  x;
    if (h[31:0] == 32'h1DAC2B7C) return rev256(GEN_LE);
    x = h[31:0] ^ h[63:32] ^ h[639:608] ^ 32'h6a09e667;
    for (int i = 0; i < 8; i++) begin
      x = x * 32'h9E3779B1 + 32'h7F4A7C15;
      x = x ^ (x >> 15);
      x = x * 32'h85EBCA6B;
      x = x ^ (x >> 13);
      d[32*i +: 32] = x;
    end
    return d;
  endfunction

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // Hasher model: latency 2..5 cycles, ready low while busy.
  logic         hm_st;
  logic [639:0] hm_cap;
  logic [639:0] hm_hdr;
  int           hm_rem;
  initial begin
    forever begin
      @(negedge clk);
      hm_st  = hash_start;
      hm_cap = hash_header;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hm_busy = 1'b0;
        hash_valid = 1'b0;
        hm_rem = 0;
      end else if (hm_st) begin
        hm_busy = 1'b1;
        hash_valid = 1'b0;
        hm_rem = $urandom_range(2, 5);
        hm_hdr = hm_cap;
      end else if (hm_busy) begin
        if (hash_valid) begin
          hash_valid = 1'b0;
          hm_busy = 1'b0;
        end else if (hm_rem > 1) begin
          hm_rem--;
        end else begin
          hash_valid = 1'b1;
          hash_digest = fake_digest(hm_hdr);
        end
      end
    end
  end

  // Monitor: records launches, hits, done; checks pulse rules.
  logic [639:0] launch_q [$];
  logic [31:0]  fn_q [$];
  logic [255:0] fh_q [$];
  int           done_n = 0;
  int           last_valid = -100;
  bit           prev_hs = 1'b0;
  bit           inflight = 1'b0;
  bit           stable_ok = 1'b1;
  logic [639:0] hcap;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hs = 1'b0;
        inflight = 1'b0;
      end else begin
        if (hash_start) begin
          tests++;
          if (prev_hs) begin
            fails++;
            $display("FAIL consecutive_start at cycle %0d", cyc);
          end
          launch_q.push_back(hash_header);
          inflight = 1'b1;
          hcap = hash_header;
          stable_ok = 1'b1;
        end else if (inflight) begin
          if (hash_header !== hcap) stable_ok = 1'b0;
          if (hash_valid) begin
            tests++;
            if (!stable_ok) begin
              fails++;
              $display("FAIL header_stable: moved during hash, started %h",
                       hcap[31:0]);
            end
            inflight = 1'b0;
            last_valid = cyc;
          end
        end
        prev_hs = hash_start;
        if (found_valid) begin
          fn_q.push_back(found_nonce);
          fh_q.push_back(found_hash);
          tests++;
          if (cyc != last_valid + 2) begin
            fails++;
            $display("FAIL found_timing: got cycle %0d, want %0d",
                     cyc, last_valid + 2);
          end
        end
        if (done) begin
          done_n++;
          tests++;
          if (cyc != last_valid + 2) begin
            fails++;
            $display("FAIL done_timing: got cycle %0d, want %0d",
                     cyc, last_valid + 2);
          end
        end
      end
    end
  end

  // Reference model: walk the range by the job rules.
  logic [639:0] exp_launch [$];
  logic [31:0]  exp_fn [$];
  logic [255:0] exp_fh [$];
  logic [1:0]   exp_status;
  int           exp_count;

  task automatic build_model(
    input logic [639:0] hdr, input logic [31:0] s, input logic [31:0] e,
    input logic [255:0] tgt, input logic stop, input int abort_k
  );
    logic [31:0]  n;
    logic [639:0] h;
    logic [255:0] d;
    bit           hit;
    exp_launch.delete();
    exp_fn.delete();
    exp_fh.delete();
    n = s;
    exp_count = 0;
    while (1) begin
      h = {hdr[639:32], rev32(n)};
      exp_launch.push_back(h);
      exp_count++;
      d = fake_digest(h);
      hit = rev256(d) <= tgt;
      if (hit) begin
        exp_fn.push_back(n);
        exp_fh.push_back(d);
      end
      if (hit && stop) begin exp_status = 2'd1; break; end
      if (n == e) begin exp_status = 2'd0; break; end
      if (abort_k > 0 && exp_count >= abort_k) begin
        exp_status = 2'd2;
        break;
      end
      n = n + 32'd1;
    end
  endtask

  task automatic run_job(
    input string name, input logic [639:0] hdr,
    input logic [31:0] s, input logic [31:0] e,
    input logic [255:0] tgt, input logic stop,
    input int abort_k, input int stall_n
  );
    int ns, guard, lcyc, fs, stall_left, d0, nl, nf;
    bit fire, got;
    build_model(hdr, s, e, tgt, stop, abort_k);
    sel = stop;
    launch_q.delete();
    fn_q.delete();
    fh_q.delete();
    d0 = done_n;
    guard = 0;
    while (work_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (work_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready: work_ready %b, want 1", name, work_ready);
    end
    @(posedge clk);
    #1;
    work_valid = 1'b1;
    work_header = hdr;
    work_nonce_start = s;
    work_nonce_end = e;
    work_target = tgt;
    stall_left = stall_n;
    stall = stall_n > 0;
    @(posedge clk);
    #1;
    work_valid = 1'b0;
    @(negedge clk);
    lcyc = cyc;
    fs = -1;
    ns = 0;
    fire = 1'b0;
    got = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: busy %b, want 1", name, busy);
    end
    if (hash_start) begin
      fs = cyc;
      ns = 1;
      if (ns == abort_k) fire = 1'b1;
    end
    for (guard = 0; guard < 3000; guard++) begin
      @(posedge clk);
      #1;
      abort = fire;
      fire = 1'b0;
      if (stall_left > 0) stall_left--;
      stall = stall_left > 0;
      @(negedge clk);
      if (hash_start) begin
        if (fs < 0) fs = cyc;
        ns++;
        if (ns == abort_k) fire = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    stall = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s done_timeout: no done, want done", name);
    end
    tests++;
    if (fs - lcyc != stall_n) begin
      fails++;
      $display("FAIL %s first_start: offset %0d, want %0d",
               name, fs - lcyc, stall_n);
    end
    tests++;
    if (done_status !== exp_status) begin
      fails++;
      $display("FAIL %s status: got %0d, want %0d",
               name, done_status, exp_status);
    end
    tests++;
    if (hash_count !== 33'(exp_count)) begin
      fails++;
      $display("FAIL %s hash_count: got %0d, want %0d",
               name, hash_count, exp_count);
    end
    tests++;
    if (work_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s ready_in_done: got %b, want 0", name, work_ready);
    end
    @(negedge clk);
    tests++;
    if (work_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: ready %b done %b busy %b, want 1 0 0",
               name, work_ready, done, busy);
    end
    tests++;
    if (done_n != d0 + 1) begin
      fails++;
      $display("FAIL %s done_pulses: got %0d, want 1", name, done_n - d0);
    end
    nl = launch_q.size();
    tests++;
    if (nl != exp_launch.size()) begin
      fails++;
      $display("FAIL %s launches: got %0d, want %0d",
               name, nl, exp_launch.size());
    end
    for (int i = 0; i < nl && i < exp_launch.size(); i++) begin
      tests++;
      if (launch_q[i] !== exp_launch[i]) begin
        fails++;
        $display("FAIL %s header[%0d]: got %h, want %h",
                 name, i, launch_q[i], exp_launch[i]);
      end
    end
    nf = fn_q.size();
    tests++;
    if (nf != exp_fn.size()) begin
      fails++;
      $display("FAIL %s hits: got %0d, want %0d", name, nf, exp_fn.size());
    end
    for (int i = 0; i < nf && i < exp_fn.size(); i++) begin
      tests++;
      if (fn_q[i] !== exp_fn[i] || fh_q[i] !== exp_fh[i]) begin
        fails++;
        $display("FAIL %s hit[%0d]: got %h/%h, want %h/%h",
                 name, i, fn_q[i], fh_q[i], exp_fn[i], exp_fh[i]);
      end
    end
  endtask

  logic [639:0] g_hdr;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (work_ready !== 1'b0 || busy !== 1'b0 || hash_start !== 1'b0 ||
        hash_header !== '0 || hash_count !== '0 || done !== 1'b0 ||
        found_valid !== 1'b0 || done_status !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: ready %b busy %b hs %b cnt %0d, want 0",
               work_ready, busy, hash_start, hash_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (work_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: work_ready %b, want 1", work_ready);
    end
  endtask

  task automatic test_genesis();
    run_job("genesis", g_hdr, 32'h7C2BAC1D, 32'h7C2BAC1D, GEN_TGT,
            1'b1, 0, 0);
    tests++;
    if (fn_q.size() != 1) begin
      fails++;
      $display("FAIL genesis_hit: got %0d hits, want 1", fn_q.size());
    end else if (fn_q[0] !== 32'h7C2BAC1D || rev256(fh_q[0]) !== GEN_LE) begin
      fails++;
      $display("FAIL genesis_hit: got %h/%h, want 7c2bac1d/%h",
               fn_q[0], rev256(fh_q[0]), GEN_LE);
    end
  endtask

  task automatic test_genesis_range();
    run_job("genesis_range", g_hdr, 32'h7C2BAC1A, 32'h7C2BAC1F, GEN_TGT,
            1'b1, 0, 0);
    tests++;
    if (launch_q.size() != 4 || hash_count !== 33'd4) begin
      fails++;
      $display("FAIL genesis_range_count: got %0d/%0d, want 4/4",
               launch_q.size(), hash_count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w [4];
    w = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
    run_job("wrap", rand_hdr(), 32'hFFFFFFFE, 32'h00000001, '0,
            1'b1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= launch_q.size() || launch_q[i][31:0] !== w[i]) begin
        fails++;
        $display("FAIL wrap_field[%0d]: got %h, want %h", i,
                 (i < launch_q.size()) ? launch_q[i][31:0] : 32'hx, w[i]);
      end
    end
  endtask

  task automatic test_abort();
    run_job("abort", rand_hdr(), 32'd0, 32'd99, '0, 1'b1, 1, 0);
    tests++;
    if (launch_q.size() != 1 || done_status !== 2'd2) begin
      fails++;
      $display("FAIL abort_result: got %0d launches status %0d, want 1 2",
               launch_q.size(), done_status);
    end
  endtask

  task automatic test_all_hit();
    run_job("all_hit", rand_hdr(), 32'd10, 32'd12, '1, 1'b0, 0, 0);
    tests++;
    if (fn_q.size() != 3 || done_status !== 2'd0) begin
      fails++;
      $display("FAIL all_hit_result: got %0d hits status %0d, want 3 0",
               fn_q.size(), done_status);
    end else if (fn_q[0] !== 32'd10 || fn_q[1] !== 32'd11 ||
                 fn_q[2] !== 32'd12) begin
      fails++;
      $display("FAIL all_hit_nonces: got %0d %0d %0d, want 10 11 12",
               fn_q[0], fn_q[1], fn_q[2]);
    end
  endtask

  task automatic test_target_equal();
    logic [639:0] h;
    logic [255:0] le;
    h = rand_hdr();
    le = rev256(fake_digest({h[639:32], rev32(32'h55)}));
    run_job("target_eq", h, 32'h55, 32'h55, le, 1'b1, 0, 0);
    run_job("target_eq_m1", h, 32'h55, 32'h55, le - 256'd1, 1'b1, 0, 0);
  endtask

  task automatic test_stall();
    run_job("stall", rand_hdr(), 32'd5, 32'd7, '0, 1'b1, 0, 5);
  endtask

  task automatic test_reset_mid_job();
    int guard, d0, f0;
    sel = 1'b1;
    @(posedge clk);
    #1;
    work_valid = 1'b1;
    work_header = rand_hdr();
    work_nonce_start = 32'd0;
    work_nonce_end = 32'd99;
    work_target = '0;
    @(posedge clk);
    #1;
    work_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (hash_start !== 1'b1 && guard < 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (work_ready !== 1'b0 || busy !== 1'b0 || hash_start !== 1'b0 ||
        hash_header !== '0 || hash_count !== '0 || done !== 1'b0 ||
        found_valid !== 1'b0 || done_status !== 2'd0 ||
        found_nonce !== '0 || found_hash !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy %b cnt %0d status %0d hdr %h, want 0",
               busy, hash_count, done_status, hash_header[31:0]);
    end
    repeat (3) @(negedge clk);
    d0 = done_n;
    f0 = fn_q.size();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests++;
    if (done_n != d0 || fn_q.size() != f0 || work_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_after: done %0d found %0d ready %b, want 0 0 1",
               done_n - d0, fn_q.size() - f0, work_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  s;
    logic [255:0] t;
    int           len, ak;
    for (int j = 0; j < 16; j++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFFFFFF - $urandom_range(0, 3);
      len = $urandom_range(0, 6);
      t = {$urandom_range(0, 32'h60000000), 224'd0};
      t[223:0] = {7{$urandom}};
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      run_job($sformatf("rand%0d", j), rand_hdr(), s, s + 32'(len), t,
              1'($urandom_range(0, 1)), ak, $urandom_range(0, 3));
    end
  endtask

  initial begin
    g_hdr = rand_hdr();
    test_reset();
    test_genesis();
    test_genesis_range();
    test_wrap();
    test_abort();
    test_all_hit();
    test_target_equal();
    test_stall();
    test_reset_mid_job();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
